// File: rtl/spi_master.sv
// spi_master: SPI mode-0 (CPOL=0, CPHA=0), MSB-first, single-slave master.
// Each byte is taken on a send_valid/send_ready handshake, framed with an
// active-low ss, and clocked out on sclk = ext_clk / (2*CLK_DIV). The byte
// returned on miso is presented on recv_data with a one-cycle recv_ready.
// Optional feature macro: SPI_MASTER_BURST_EN. When it is defined, a new byte
// can be accepted in the final HOLD cycle, so consecutive bytes share one ss
// frame.

module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       ext_clk,
  input  logic       rst,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss,
  input  logic [7:0] send_data,
  input  logic       send_valid,
  output logic       send_ready,
  output logic [7:0] recv_data,
  output logic       recv_ready
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] div_cnt, div_nxt;
  logic [3:0] bit_cnt, bit_nxt;
  logic [7:0] tx_sr, tx_nxt;
  logic [7:0] rx_sr, rx_nxt;
  logic       sclk_nxt, mosi_nxt, ss_nxt, recv_ready_nxt;
  logic [7:0] recv_data_nxt;
  logic       div_done;
  logic       accept;

  assign div_done = (div_cnt == DIV_LAST);

`ifdef SPI_MASTER_BURST_EN
  logic hold_last;
  assign hold_last  = (state == HOLD) && div_done;
  assign send_ready = (state == IDLE) || hold_last;
`else
  assign send_ready = (state == IDLE);
`endif

  assign accept = send_valid && send_ready;

  // Next-state and next-output logic; bit_cnt counts sclk half-periods in SHIFT
  always_comb begin
    state_nxt      = state;
    div_nxt        = div_cnt;
    bit_nxt        = bit_cnt;
    tx_nxt         = tx_sr;
    rx_nxt         = rx_sr;
    sclk_nxt       = sclk;
    mosi_nxt       = mosi;
    ss_nxt         = ss;
    recv_data_nxt  = recv_data;
    recv_ready_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          tx_nxt    = send_data;
          rx_nxt    = 8'h00;
          mosi_nxt  = send_data[7];
          ss_nxt    = 1'b0;
          div_nxt   = 8'd0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (div_done) begin
          div_nxt   = 8'd0;
          bit_nxt   = 4'd0;
          sclk_nxt  = 1'b1;
          rx_nxt    = {rx_sr[6:0], miso};
          state_nxt = SHIFT;
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (div_done) begin
          div_nxt = 8'd0;
          if (bit_cnt == 4'd15) begin
            state_nxt = HOLD;
          end else begin
            bit_nxt = bit_cnt + 4'd1;
            if (!sclk) begin
              sclk_nxt = 1'b1;
              rx_nxt   = {rx_sr[6:0], miso};
            end else begin
              sclk_nxt = 1'b0;
              tx_nxt   = {tx_sr[6:0], 1'b0};
              if (bit_cnt != 4'd14) begin
                mosi_nxt = tx_sr[6];
              end
            end
          end
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      HOLD: begin
        if (div_done) begin
          div_nxt        = 8'd0;
          recv_data_nxt  = rx_sr;
          recv_ready_nxt = 1'b1;
          ss_nxt         = 1'b1;
          state_nxt      = GAP;
`ifdef SPI_MASTER_BURST_EN
          if (accept) begin
            tx_nxt    = send_data;
            rx_nxt    = 8'h00;
            mosi_nxt  = send_data[7];
            ss_nxt    = 1'b0;
            state_nxt = SETUP;
          end
`endif
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      GAP: begin
        if (div_done) begin
          div_nxt   = 8'd0;
          state_nxt = IDLE;
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge ext_clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= 8'd0;
      bit_cnt    <= 4'd0;
      tx_sr      <= 8'h00;
      rx_sr      <= 8'h00;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      ss         <= 1'b1;
      recv_data  <= 8'h00;
      recv_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      bit_cnt    <= bit_nxt;
      tx_sr      <= tx_nxt;
      rx_sr      <= rx_nxt;
      sclk       <= sclk_nxt;
      mosi       <= mosi_nxt;
      ss         <= ss_nxt;
      recv_data  <= recv_data_nxt;
      recv_ready <= recv_ready_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: bench for spi_master. A cycle-offset model predicts every
// output of the CLK_DIV=4 instance from the handshake time and the sampled
// miso; a second instance runs with CLK_DIV=255.

module tb_spi_master;

  localparam int D = 4;
  localparam int DS = 255;
`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       ext_clk;
  logic       rst;
  logic       sclk, mosi, miso, ss;
  logic [7:0] send_data;
  logic       send_valid, send_ready;
  logic [7:0] recv_data;
  logic       recv_ready;

  logic       s_sclk, s_mosi, s_miso, s_ss;
  logic [7:0] s_send_data;
  logic       s_send_valid, s_send_ready;
  logic [7:0] s_recv_data;
  logic       s_recv_ready;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  spi_master #(.CLK_DIV(D)) dut (
    .ext_clk(ext_clk), .rst(rst), .sclk(sclk), .mosi(mosi), .miso(miso),
    .ss(ss), .send_data(send_data), .send_valid(send_valid),
    .send_ready(send_ready), .recv_data(recv_data), .recv_ready(recv_ready)
  );

  spi_master #(.CLK_DIV(DS)) dut_slow (
    .ext_clk(ext_clk), .rst(rst), .sclk(s_sclk), .mosi(s_mosi), .miso(s_miso),
    .ss(s_ss), .send_data(s_send_data), .send_valid(s_send_valid),
    .send_ready(s_send_ready), .recv_data(s_recv_data), .recv_ready(s_recv_ready)
  );

  initial ext_clk = 1'b0;
  always #5 ext_clk = ~ext_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference model: position inside a transfer is m_t, the cycle count since the accept edge
  int         cyc = 0;
  int         acc_lbl = 0;
  int         acc_count = 0;
  bit         m_act = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_rx = 8'h00;
  logic       e_ss = 1'b1, e_sclk = 1'b0, e_mosi = 1'b0, e_ready = 1'b1, e_rready = 1'b0;
  logic [7:0] e_rdata = 8'h00;

  always @(posedge ext_clk) begin
    bit acc;
    int k;
    int f;
    cyc++;
    acc = send_valid && e_ready && !rst;
    if (rst) begin
      m_act    = 1'b0;
      e_mosi   = 1'b0;
      e_rdata  = 8'h00;
      e_rready = 1'b0;
    end else begin
      e_rready = 1'b0;
      if (m_act) begin
        m_t++;
        k = (m_t - 1) / D;
        if ((m_t - 1) % D == 0 && k % 2 == 1 && k <= 15) m_rx = {m_rx[6:0], miso};
        if (m_t == 1 + 18 * D) begin
          e_rdata  = m_rx;
          e_rready = 1'b1;
        end
        if (m_t == 1 + 19 * D) m_act = 1'b0;
      end
      if (acc) begin
        m_act  = 1'b1;
        m_t    = 1;
        m_byte = send_data;
        m_rx   = 8'h00;
        acc_lbl = cyc - 1;
        acc_count++;
      end
      if (m_act) begin
        k = (m_t - 1) / D;
        f = (k / 2 > 7) ? 7 : k / 2;
        e_mosi = m_byte[7 - f];
      end
    end
    k = (m_t - 1) / D;
    e_ss    = !(m_act && m_t <= 18 * D);
    e_sclk  = m_act && k >= 1 && k <= 15 && (k % 2 == 1);
    e_ready = !m_act || (BURST && m_t == 18 * D);
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge ext_clk) begin
    if (chk_en) begin
      checkOutput("ss", 32'(ss), 32'(e_ss));
      checkOutput("sclk", 32'(sclk), 32'(e_sclk));
      checkOutput("mosi", 32'(mosi), 32'(e_mosi));
      checkOutput("send_ready", 32'(send_ready), 32'(e_ready));
      checkOutput("recv_ready", 32'(recv_ready), 32'(e_rready));
      checkOutput("recv_data", 32'(recv_data), 32'(e_rdata));
    end
  end

  // Slave side stimulus: delayed loopback, a fixed reply byte, or random bits
  int         miso_mode = 0;
  logic [7:0] slave_byte = 8'h00;
  int         slave_idx = 7;
  logic       mosi_d1 = 1'b0, mosi_d2 = 1'b0, sclk_prev = 1'b0;

  initial miso = 1'b0;
  always @(posedge ext_clk) begin
    #1;
    if (ss !== 1'b0) slave_idx = 7;
    else if (sclk_prev && !sclk && slave_idx > 0) slave_idx--;
    sclk_prev = sclk;
    mosi_d2 = mosi_d1;
    mosi_d1 = mosi;
    case (miso_mode)
      0:       miso = mosi_d2;
      1:       miso = slave_byte[slave_idx];
      default: miso = 1'($urandom_range(0, 1));
    endcase
  end

  // Observation counters used by the directed checks
  int   rise_cnt, frame_cnt, strobe_cnt, ss_rise_lbl, ready_ret_lbl, ss_high_run, min_gap;
  int   strobe_q[$];
  logic mosi_bits[$];
  logic [7:0] last_rdata;
  logic p_sclk = 1'b0, p_ss = 1'b1, p_ready = 1'b1;

  task automatic clearMonitor();
    rise_cnt = 0; frame_cnt = 0; strobe_cnt = 0; ss_rise_lbl = -1; ready_ret_lbl = -1;
    ss_high_run = 0; min_gap = 1000; strobe_q.delete(); mosi_bits.delete(); last_rdata = 8'h00;
  endtask

  always @(negedge ext_clk) begin
    if (chk_en) begin
      if (sclk && !p_sclk) begin
        rise_cnt++;
        mosi_bits.push_back(mosi);
      end
      if (!ss && p_ss) begin
        if (frame_cnt > 0 && ss_high_run < min_gap) min_gap = ss_high_run;
        frame_cnt++;
      end
      if (ss && !p_ss) ss_rise_lbl = cyc;
      ss_high_run = ss ? ss_high_run + 1 : 0;
      if (recv_ready) begin
        strobe_cnt++;
        strobe_q.push_back(cyc);
        last_rdata = recv_data;
      end
      if (send_ready && !p_ready) ready_ret_lbl = cyc;
      p_sclk = sclk; p_ss = ss; p_ready = send_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ext_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n0 = acc_count;
    int g = 0;
    send_valid = 1'b1;
    send_data  = b;
    while (acc_count == n0 && g < 200) begin
      tick(1);
      g++;
    end
    send_valid = 1'b0;
    if (acc_count == n0) failTimeout("accept");
  endtask

  task automatic waitIdle();
    int g = 0;
    while (m_act && g < 400) begin
      tick(1);
      g++;
    end
    if (m_act) failTimeout("idle");
    tick(2);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic slowTest();
    int hi_len = 0, lo_len = 0, rises = 0, ss_low = 0, g = 0;
    logic ps = 1'b0, first_bit = 1'b0, seen = 1'b0;
    logic [7:0] got = 8'h00;
    s_miso = 1'b1;
    s_send_data = 8'hC3;
    checkOutput("slow_ready_idle", 32'(s_send_ready), 32'd1);
    s_send_valid = 1'b1;
    tick(1);
    s_send_valid = 1'b0;
    while (!seen && g < 6000) begin
      @(negedge ext_clk);
      g++;
      if (!s_ss) ss_low++;
      if (s_sclk && !ps) begin
        rises++;
        if (rises == 1) first_bit = s_mosi;
      end
      if (rises == 1 && s_sclk) hi_len++;
      if (rises == 1 && !s_sclk) lo_len++;
      if (s_recv_ready) begin
        seen = 1'b1;
        got = s_recv_data;
      end
      ps = s_sclk;
    end
    if (!seen) failTimeout("slow_strobe");
    checkOutput("slow_high_half", 32'(hi_len), 32'd255);
    checkOutput("slow_low_half", 32'(lo_len), 32'd255);
    checkOutput("slow_rises", 32'(rises), 32'd8);
    checkOutput("slow_ss_low", 32'(ss_low), 32'd4590);
    checkOutput("slow_first_bit", 32'(first_bit), 32'd1);
    checkOutput("slow_recv", 32'(got), 32'hFF);
    tick(2 * DS + 4);
  endtask

  logic [7:0] burst_bytes [4];

  initial begin
    int n0, g, v;
    rst = 1'b1;
    send_valid = 1'b0; send_data = 8'h00;
    s_send_valid = 1'b0; s_send_data = 8'h00; s_miso = 1'b0;
    clearMonitor();
    @(posedge ext_clk);
    #1;
    chk_en = 1'b1;
    tick(2);
    rst = 1'b0;

    // Reset values
    checkOutput("rst_ss", 32'(ss), 32'd1);
    checkOutput("rst_sclk", 32'(sclk), 32'd0);
    checkOutput("rst_mosi", 32'(mosi), 32'd0);
    checkOutput("rst_send_ready", 32'(send_ready), 32'd1);
    checkOutput("rst_recv_ready", 32'(recv_ready), 32'd0);
    tick(2);

    // Loopback of 0x02
    $display("[TB] loopback 0x02");
    miso_mode = 0;
    clearMonitor();
    applyStimulus(8'h02);
    waitIdle();
    checkOutput("lb_rises", 32'(rise_cnt), 32'd8);
    v = 0;
    for (int i = 0; i < 8; i++) v = (v << 1) | ((i < mosi_bits.size()) ? int'(mosi_bits[i]) : 0);
    checkOutput("lb_mosi_bits", 32'(v), 32'h02);
    checkOutput("lb_recv", 32'(last_rdata), 32'h02);
    checkOutput("lb_strobe_cyc", 32'((strobe_q.size() > 0) ? strobe_q[0] - acc_lbl : -1), 32'd73);
    checkOutput("lb_ready_cyc", 32'(ready_ret_lbl - acc_lbl), 32'd77);

    // Slave replies 0xA5 while 0x03 is sent
    $display("[TB] slave reply 0xA5");
    miso_mode = 1;
    slave_byte = 8'hA5;
    clearMonitor();
    applyStimulus(8'h03);
    waitIdle();
    checkOutput("sl_recv", 32'(last_rdata), 32'hA5);
    checkOutput("sl_strobes", 32'(strobe_cnt), 32'd1);
    checkOutput("sl_strobe_ss", 32'((strobe_q.size() > 0) ? strobe_q[0] : -1), 32'(ss_rise_lbl));

    // Reset at sclk edge 7
    $display("[TB] reset mid-transfer");
    miso_mode = 0;
    applyStimulus(8'h5A);
    g = 0;
    while (m_t != 1 + 7 * D && g < 100) begin
      tick(1);
      g++;
    end
    if (m_t != 1 + 7 * D) failTimeout("edge7");
    checkOutput("mid_sclk_high", 32'(sclk), 32'd1);
    clearMonitor();
    pulseReset();
    checkOutput("mid_ss", 32'(ss), 32'd1);
    checkOutput("mid_sclk", 32'(sclk), 32'd0);
    tick(100);
    checkOutput("mid_no_strobe", 32'(strobe_cnt), 32'd0);
    applyStimulus(8'h01);
    waitIdle();
    checkOutput("mid_after_recv", 32'(last_rdata), 32'h01);

    // send_valid held across four bytes
    $display("[TB] held send_valid");
    burst_bytes = '{8'h02, 8'h01, 8'hFF, 8'h03};
    clearMonitor();
    n0 = acc_count;
    g = 0;
    send_data = burst_bytes[0];
    send_valid = 1'b1;
    while (acc_count - n0 < 4 && g < 1000) begin
      tick(1);
      g++;
      if (acc_count - n0 < 4) send_data = burst_bytes[acc_count - n0];
    end
    send_valid = 1'b0;
    if (acc_count - n0 < 4) failTimeout("held_accepts");
    waitIdle();
    checkOutput("held_rises", 32'(rise_cnt), 32'd32);
    checkOutput("held_strobes", 32'(strobe_cnt), 32'd4);
    checkOutput("held_last_recv", 32'(last_rdata), 32'h03);
    for (int i = 0; i < 3; i++) begin
      checkOutput("held_spacing",
                  32'((strobe_q.size() > i + 1) ? strobe_q[i + 1] - strobe_q[i] : -1),
                  BURST ? 32'd72 : 32'd77);
    end
    checkOutput("held_frames", 32'(frame_cnt), BURST ? 32'd1 : 32'd4);
    if (!BURST) checkOutput("held_ss_gap", 32'(min_gap >= D), 32'd1);

    // Randomized transfers with occasional resets
    $display("[TB] random transfers");
    miso_mode = 2;
    for (int it = 0; it < 40; it++) begin
      tick($urandom_range(0, 6));
      applyStimulus(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 5) == 0) begin
        tick($urandom_range(1, 75));
        pulseReset();
      end else begin
        waitIdle();
      end
    end
    waitIdle();

    // CLK_DIV=255 instance
    $display("[TB] CLK_DIV=255");
    slowTest();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 (CPOL=0, CPHA=0), MSB-first, single-slave master that drives the `spi_slave` bus from the system clock domain. It accepts one byte per valid/ready handshake, generates `sclk` by integer division of `ext_clk`, and frames each byte with `ss`. It captures the slave's `miso` byte and presents it with a one-cycle strobe. It sits on the host/controller side, opposite `spi_slave`, for command and link-level testing.

## Interface
- `CLK_DIV`, 4, `ext_clk` cycles per `sclk` half-period; legal range 4..255, which covers the slave's input-synchronizer latency.
- `ext_clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous to `ext_clk`, active-high.
- `sclk`  out  1  SPI clock; idles low.
- `mosi`  out  1  master-out data; changes only while `sclk` is low.
- `miso`  in  1  slave-out data; sampled on `sclk` rising edges.
- `ss`  out  1  slave select, active-low.
- `send_data`  in  8  byte to transmit; sampled on handshake.
- `send_valid`  in  1  host has a byte.
- `send_ready`  out  1  master can accept a byte; a transfer starts when `send_valid && send_ready`.
- `recv_data`  out  8  last byte received; held until the next byte completes.
- `recv_ready`  out  1  one-cycle strobe: `recv_data` has been updated.

## Operation
- FSM states are IDLE, SETUP, SHIFT, HOLD and GAP. A divider counter runs 0..CLK_DIV-1 and a bit counter runs 0..15, counting half-periods.
- IDLE
  - `send_ready`=1, `ss`=1, `sclk`=0.
  - On handshake: latch `send_data` into the TX shift register, drive `mosi`=bit7 and `ss`=0, then go to SETUP.
- SETUP: wait CLK_DIV cycles, then go to SHIFT.
- SHIFT: toggle `sclk` every CLK_DIV cycles, 16 toggles in total.
  - Rising edge: the same register update that sets `sclk`=1 shifts `miso` into the RX shift register LSB.
  - Falling edge: the TX register shifts left and `mosi` takes the next bit.
  - After the 8th falling edge, `mosi` holds bit0 and the FSM goes to HOLD.
- HOLD
  - Wait CLK_DIV cycles with `ss` low and `sclk` low.
  - On exit: `ss`=1, `recv_data`<=RX register, `recv_ready`=1 for one cycle, then go to GAP.
- GAP: `ss`=1 for CLK_DIV cycles, then go to IDLE.
- `send_valid` is ignored outside IDLE, except in the final HOLD cycle when SPI_MASTER_BURST_EN is defined.
- Reset values: `sclk`=0, `mosi`=0, `ss`=1, `recv_data`=0, `recv_ready`=0, FSM=IDLE, so `send_ready`=1 in the first cycle after reset.
- Reset mid-transfer:
  - All outputs return to their reset values at that edge.
  - The partial RX byte is discarded and no `recv_ready` is issued.
  - A handshake is not accepted in a cycle where `rst`=1.

## Timing
- Accept edge = cycle 0. The effects of the accept edge are visible from cycle 1: `ss` falls and `mosi`=bit7.
- Edge *k* (k=1..16) of `sclk` occurs at cycle 1+k·CLK_DIV; odd k are rising edges, even k are falling edges.
- `ss` is low for exactly 18·CLK_DIV cycles. It rises together with the `recv_ready` pulse at cycle 1+18·CLK_DIV.
- `send_ready` returns at cycle 1+19·CLK_DIV. The non-burst byte period is therefore 19·CLK_DIV+1 cycles.
- `mosi` setup to a rising edge is CLK_DIV cycles; hold after a falling edge is 0.
- `recv_ready` never lasts more than one cycle. `recv_data` is stable between strobes.

## Configuration
- `SPI_MASTER_BURST_EN` defined:
  - `send_ready` is also 1 in the final HOLD cycle.
  - A handshake there loads the next byte, keeps `ss` low, pulses `recv_ready` for the finished byte, and re-enters SETUP, skipping GAP.
  - Back-to-back bytes cost 18·CLK_DIV cycles each, with one continuous `ss` frame.
- Not defined: every byte is individually framed with `ss` and followed by GAP; `send_ready` is asserted only in IDLE.

## Test plan
- Reset with CLK_DIV=4 → `ss`=1, `sclk`=0, `mosi`=0, `send_ready`=1, `recv_ready`=0.
- Send 0x02 to a loopback model (`miso`=`mosi`, delayed 2 cycles) → 8 rising `sclk` edges, `mosi` bits 0,0,0,0,0,0,1,0, `recv_data`=0x02 strobed at cycle 73, `send_ready` back at cycle 77.
- Slave model returning 0xA5 while 0x03 is sent → `recv_data`=0xA5, exactly one `recv_ready` pulse, coincident with `ss` rising.
- Assert `rst` at sclk edge 7 of a transfer → `ss`=1 and `sclk`=0 on the next cycle, no `recv_ready`; a following send of 0x01 completes normally.
- Hold `send_valid` high with bytes 0x02, 0x01, 0xFF, 0x03 → without the macro: four `ss` frames separated by ≥CLK_DIV high cycles. With `SPI_MASTER_BURST_EN`: one `ss` frame, 32 rising edges, four `recv_ready` pulses spaced 72 cycles apart.
- CLK_DIV=255 sanity → `sclk` half-period of exactly 255 cycles, with no counter wrap errors.
